// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the digit-serial BCD adder/subtractor.
// Optional feature macro in this slice: BCD_INPUT_CHECK_EN (adds err output).
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_CORR    = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one-digit combinational BCD adder with decimal correction.
// Macro BCD_INPUT_CHECK_EN adds the invalid-digit output.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       cin,
    output logic [3:0] s_d,
`ifdef BCD_INPUT_CHECK_EN
    output logic       invalid,
`endif
    output logic       cout
);

    logic [4:0] raw;

    // binary sum then +6 correction whenever the digit overflows nine
    always_comb begin
        raw  = {1'b0, a_d} + {1'b0, b_d} + {4'd0, cin};
        s_d  = raw[3:0];
        cout = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            s_d  = raw[3:0] + BCD_CORR;
            cout = 1'b1;
        end
    end

`ifdef BCD_INPUT_CHECK_EN
    // nines(b) > 9 exactly when b > 9, so checking the muxed digit suffices
    always_comb begin
        invalid = (a_d > BCD_MAX) || (b_d > BCD_MAX);
    end
`endif

endmodule

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial BCD add/subtract, LSD first, one digit per clk.
// Macro BCD_INPUT_CHECK_EN adds err, flagging any latched digit above nine.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter  int N_DIGITS = 4,
    localparam int W        = 4 * N_DIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         valid,
    output logic [W-1:0] sum,
`ifdef BCD_INPUT_CHECK_EN
    output logic         err,
`endif
    output logic         cout
);

    localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_DIGITS - 1);

    state_t        state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic          mode_r;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [3:0]    b_eff;
    logic [3:0]    s_d;
    logic          d_cout;
`ifdef BCD_INPUT_CHECK_EN
    logic          d_inv;
    logic          err_acc;
`endif

    // subtract uses the nines-complement of each B digit
    always_comb begin
        b_eff = b_sr[3:0];
        if (mode_r) begin
            b_eff = BCD_MAX - b_sr[3:0];
        end
    end

    bcd_digit_add u_dig (
        .a_d     (a_sr[3:0]),
        .b_d     (b_eff),
        .cin     (carry),
        .s_d     (s_d),
`ifdef BCD_INPUT_CHECK_EN
        .invalid (d_inv),
`endif
        .cout    (d_cout)
    );

    // control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            valid  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            mode_r <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
            err     <= 1'b0;
            err_acc <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        mode_r <= mode;
                        carry  <= mode ? ~cin : cin;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        state  <= RUN;
`ifdef BCD_INPUT_CHECK_EN
                        err_acc <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> BCD_DIGIT_W;
                    b_sr  <= b_sr >> BCD_DIGIT_W;
                    sum   <= (sum >> BCD_DIGIT_W)
                           | (W'(s_d) << (W - BCD_DIGIT_W));
                    carry <= d_cout;
                    cnt   <= cnt + 1'b1;
`ifdef BCD_INPUT_CHECK_EN
                    err_acc <= err_acc | d_inv;
`endif
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    valid <= 1'b1;
                    cout  <= carry;
                    ready <= 1'b1;
                    state <= IDLE;
`ifdef BCD_INPUT_CHECK_EN
                    err <= err_acc;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb_bcd_serial_addsub: randomized and directed checks against a decimal model.
// Define BCD_INPUT_CHECK_EN to also exercise the err output.
module tb_bcd_serial_addsub;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         valid;
    logic [W-1:0] sum;
    logic         cout;
`ifdef BCD_INPUT_CHECK_EN
    logic         err;
`endif

    int checks = 0;
    int errors = 0;

    bcd_serial_addsub #(.N_DIGITS(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .ready (ready),
        .valid (valid),
        .sum   (sum),
`ifdef BCD_INPUT_CHECK_EN
        .err   (err),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint pow10n();
        longint p = 1;
        for (int i = 0; i < N; i++) p = p * 10;
        return p;
    endfunction

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        longint w = 1;
        for (int i = 0; i < N; i++) begin
            r = r + longint'(v[4*i +: 4]) * w;
            w = w * 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint x);
        logic [W-1:0] r = '0;
        longint t = x;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // decimal reference: plain integer arithmetic modulo 10^N
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mm, input logic mc,
                         output logic [W-1:0] es, output logic ec);
        longint p = pow10n();
        longint r;
        if (!mm) begin
            r  = bcd2int(ma) + bcd2int(mb) + longint'(mc);
            ec = (r >= p);
            es = int2bcd(r % p);
        end else begin
            r  = bcd2int(ma) - bcd2int(mb) - longint'(mc);
            ec = (r >= 0);
            es = int2bcd(r < 0 ? r + p : r);
        end
    endtask

    // issue one operation and wait for its valid pulse
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tm, input logic tc,
                         output logic [W-1:0] rs, output logic rc,
                         output int lat);
        int guard = 0;
        while (!ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a = ta; b = tb_; mode = tm; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        mode = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = sum;
        rc = cout;
    endtask

    task automatic check_op(input string nm, input logic [W-1:0] ta,
                            input logic [W-1:0] tb_, input logic tm,
                            input logic tc);
        logic [W-1:0] es, rs, held;
        logic ec, rc;
        int lat;
        model(ta, tb_, tm, tc, es, ec);
        do_op(ta, tb_, tm, tc, rs, rc, lat);
        checks++;
        if (lat !== N + 1) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", nm, lat, N + 1);
        end
        checks++;
        if (rs !== es || rc !== ec) begin
            errors++;
            $display("FAIL %s result got %h/%b want %h/%b", nm, rs, rc, es, ec);
        end
        held = sum;
        @(posedge clk); #1;
        checks++;
        if (valid !== 1'b0 || ready !== 1'b1 || sum !== held) begin
            errors++;
            $display("FAIL %s pulse/hold got v=%b r=%b s=%h want v=0 r=1 s=%h",
                     nm, valid, ready, sum, held);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset got r=%b v=%b s=%h c=%b want r=1 v=0 s=0 c=0",
                     ready, valid, sum, cout);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        check_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0);
        check_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0);
        check_op("add_0_0_cin",   16'h0000, 16'h0000, 1'b0, 1'b1);
        check_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 1'b0);
        check_op("sub_0100_0200", 16'h0100, 16'h0200, 1'b1, 1'b0);
        check_op("sub_0_0_bin",   16'h0000, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            check_op("random", rand_bcd(), rand_bcd(),
                     1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] es;
        logic ec;
        int pulses = 0;
        logic [W-1:0] got_s = '0;
        logic got_c = 1'b0;
        model(16'h4321, 16'h1111, 1'b0, 1'b0, es, ec);
        a = 16'h4321; b = 16'h1111; mode = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h9999; b = 16'h9999; mode = 1'b1; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3 * (N + 2); i++) begin
            if (valid) begin
                pulses++;
                got_s = sum;
                got_c = cout;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_start pulses got %0d want 1", pulses);
        end
        checks++;
        if (got_s !== es || got_c !== ec) begin
            errors++;
            $display("FAIL ignore_start result got %h/%b want %h/%b",
                     got_s, got_c, es, ec);
        end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        a = 16'h9999; b = 16'h9999; mode = 1'b0; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL abort got r=%b v=%b s=%h c=%b want r=1 v=0 s=0 c=0",
                     ready, valid, sum, cout);
        end
        for (int i = 0; i < N + 4; i++) begin
            if (valid) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_valid pulses got %0d want 0", pulses);
        end
        check_op("after_abort", 16'h0876, 16'h0125, 1'b0, 1'b0);
    endtask

    task automatic test_rst_start();
        a = 16'h1111; b = 16'h1111; mode = 1'b0; cin = 1'b0;
        start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_start ready got %b want 1", ready);
        end
    endtask

`ifdef BCD_INPUT_CHECK_EN
    task automatic test_err();
        logic [W-1:0] rs;
        logic rc;
        int lat;
        do_op(16'h00A0, 16'h0000, 1'b0, 1'b0, rs, rc, lat);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b want 1", err);
        end
        @(posedge clk); #1;
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, rs, rc, lat);
        checks++;
        if (err !== 1'b0 || rs !== 16'h6912) begin
            errors++;
            $display("FAIL err_clear got %b/%h want 0/6912", err, rs);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_abort();
        test_rst_start();
`ifdef BCD_INPUT_CHECK_EN
        test_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
